game_tick_scheduler: RTL and testbench

- Central time-base controller for the snake game. One free-running prescaler produces the 20 kHz display strobe and the 1 kHz strobe.
- The 1 kHz strobe drives a level-dependent game-step strobe, gated by a run/pause/over state machine.
- Speed-level changes arrive through a valid/ack handshake and are applied only on step boundaries, so a movement interval never has a mixed period.

---
 rtl/game_tick_scheduler.sv | 139 +++++++++++++
 tb/tb_game_tick_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : game_tick_scheduler
// Brief   : Prescaled 20 kHz / 1 kHz strobes plus a level-paced game STEP gated
//           by an IDLE/RUN/PAUSE/OVER state machine with a level handshake.
// Revision: 1.0
// ============================================================================
module game_tick_scheduler #(
    parameter int FAST_DIV  = 5000,
    parameter int KHZ_DIV   = 20,
    parameter int STEP_BASE = 400,
    parameter int STEP_DEC  = 40,
    parameter int MAX_LEVEL = 7
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       PAUSE_TOGGLE,
    input  logic       GAME_OVER,
    input  logic [2:0] LEVEL_REQ,
    input  logic       LEVEL_REQ_VALID,
    output logic       LEVEL_ACK,
    output logic [2:0] LEVEL,
    output logic       CE_20K,
    output logic       CE_1K,
    output logic       STEP,
    output logic       RUNNING,
    output logic       PAUSED,
    output logic       OVER
);

    localparam int c_FAST_W = (FAST_DIV  > 1) ? $clog2(FAST_DIV)  : 1;
    localparam int c_KHZ_W  = (KHZ_DIV   > 1) ? $clog2(KHZ_DIV)   : 1;
    localparam int c_STEP_W = (STEP_BASE > 1) ? $clog2(STEP_BASE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_FAST_W-1:0]   r_fast_cnt;
    logic [c_KHZ_W-1:0]    r_khz_cnt;
    logic [c_STEP_W-1:0]   r_step_cnt;
    logic [2:0]            r_level;
    logic                  r_ack;

    logic                  w_ce_20k;
    logic                  w_ce_1k;
    logic [c_STEP_W-1:0]   w_period_m1;
    logic                  w_leave_run;
    logic                  w_step;
    logic                  w_accept;
    logic [2:0]            w_req_clamped;

    assign w_ce_20k      = (r_fast_cnt == c_FAST_W'(FAST_DIV - 1));
    assign w_ce_1k       = w_ce_20k && (r_khz_cnt == c_KHZ_W'(KHZ_DIV - 1));
    assign w_period_m1   = c_STEP_W'(STEP_BASE - 1 - int'(r_level) * STEP_DEC);
    // A step that coincides with leaving RUN is swallowed, never emitted.
    assign w_leave_run   = (r_state == ST_RUN) && (GAME_OVER || PAUSE_TOGGLE);
    assign w_step        = (r_state == ST_RUN) && w_ce_1k &&
                           (r_step_cnt == w_period_m1) && !w_leave_run;
    // Blocking acceptance during the ACK cycle avoids double-accepting a requester.
    assign w_accept      = LEVEL_REQ_VALID && !r_ack &&
                           ((r_state != ST_RUN) || w_step);
    assign w_req_clamped = (LEVEL_REQ > 3'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : LEVEL_REQ;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_fast_cnt <= '0;
            r_khz_cnt  <= '0;
            r_step_cnt <= '0;
            r_level    <= '0;
            r_ack      <= 1'b0;
        end else begin
            if (w_ce_20k) begin
                r_fast_cnt <= '0;
                if (r_khz_cnt == c_KHZ_W'(KHZ_DIV - 1)) begin
                    r_khz_cnt <= '0;
                end else begin
                    r_khz_cnt <= r_khz_cnt + c_KHZ_W'(1);
                end
            end else begin
                r_fast_cnt <= r_fast_cnt + c_FAST_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state    <= ST_RUN;
                        r_step_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (GAME_OVER) begin
                        r_state <= ST_OVER;
                    end else if (PAUSE_TOGGLE) begin
                        r_state <= ST_PAUSE;
                    end else if (w_ce_1k) begin
                        r_step_cnt <= w_step ? '0 : r_step_cnt + c_STEP_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (GAME_OVER) begin
                        r_state <= ST_OVER;
                    end else if (PAUSE_TOGGLE) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (!GAME_OVER && START) begin
                        r_state    <= ST_RUN;
                        r_step_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            r_ack <= w_accept;
            if (w_accept) begin
                r_level <= w_req_clamped;
            end
        end
    end

    assign LEVEL_ACK = r_ack;
    assign LEVEL     = r_level;
    assign CE_20K    = w_ce_20k;
    assign CE_1K     = w_ce_1k;
    assign STEP      = w_step;
    assign RUNNING   = (r_state == ST_RUN);
    assign PAUSED    = (r_state == ST_PAUSE);
    assign OVER      = (r_state == ST_OVER);

endmodule
`default_nettype wire

// File: tb/tb_game_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_game_tick_scheduler
// Brief   : Directed self-checking bench for game_tick_scheduler (small dividers).
// Revision: 1.0
// ============================================================================
module tb_game_tick_scheduler;

    logic       CLOCK;
    logic       RESET;
    logic       START;
    logic       PAUSE_TOGGLE;
    logic       GAME_OVER;
    logic [2:0] LEVEL_REQ;
    logic       LEVEL_REQ_VALID;
    logic       LEVEL_ACK;
    logic [2:0] LEVEL;
    logic       CE_20K;
    logic       CE_1K;
    logic       STEP;
    logic       RUNNING;
    logic       PAUSED;
    logic       OVER;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    game_tick_scheduler #(
        .FAST_DIV (4),
        .KHZ_DIV  (5),
        .STEP_BASE(10),
        .STEP_DEC (1),
        .MAX_LEVEL(7)
    ) u_dut (
        .CLOCK          (CLOCK),
        .RESET          (RESET),
        .START          (START),
        .PAUSE_TOGGLE   (PAUSE_TOGGLE),
        .GAME_OVER      (GAME_OVER),
        .LEVEL_REQ      (LEVEL_REQ),
        .LEVEL_REQ_VALID(LEVEL_REQ_VALID),
        .LEVEL_ACK      (LEVEL_ACK),
        .LEVEL          (LEVEL),
        .CE_20K         (CE_20K),
        .CE_1K          (CE_1K),
        .STEP           (STEP),
        .RUNNING        (RUNNING),
        .PAUSED         (PAUSED),
        .OVER           (OVER)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        cyc++;
    endtask

    // Advance to the target cycle; no STEP or ACK may appear on the way.
    task automatic run_until(input int target, input string tag);
        int st = 0;
        int ak = 0;
        while (cyc < target) begin
            if (STEP === 1'b1) st++;
            if (LEVEL_ACK === 1'b1) ak++;
            tick();
        end
        check({tag, "_nostep"}, st, 0);
        check({tag, "_noack"}, ak, 0);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; PAUSE_TOGGLE = 1'b0; GAME_OVER = 1'b0;
        LEVEL_REQ = 3'd0; LEVEL_REQ_VALID = 1'b0;
        repeat (2) tick();
        check("rst_status", {RUNNING, PAUSED, OVER, STEP, LEVEL_ACK}, 0);
        check("rst_level", LEVEL, 0);
        check("rst_ce", {CE_20K, CE_1K}, 0);
        RESET = 1'b0;
        cyc = 1;

        // Idle prescaler: CE_20K every 4th cycle, CE_1K every 20th
        for (int i = 0; i < 60; i++) begin
            check("t1_ce20k", CE_20K, (cyc % 4) == 0);
            check("t1_ce1k", CE_1K, (cyc % 20) == 0);
            check("t1_status", {STEP, RUNNING, PAUSED, OVER, LEVEL_ACK}, 0);
            tick();
        end

        // START: RUN, steps on every 10th CE_1K
        START = 1'b1;
        tick();
        START = 1'b0;
        check("t2_running", RUNNING, 1);
        run_until(260, "t2a");
        check("t2_step1", STEP, 1);
        check("t2_step1_ce1k", CE_1K, 1);
        tick();
        check("t2_step_width", STEP, 0);
        run_until(460, "t2b");
        check("t2_step2", STEP, 1);

        // Level 3 request mid-interval waits for the STEP boundary
        tick();
        run_until(500, "t3a");
        LEVEL_REQ = 3'd3; LEVEL_REQ_VALID = 1'b1;
        run_until(660, "t3b");
        check("t3_step", STEP, 1);
        check("t3_level_before", LEVEL, 0);
        tick();
        check("t3_ack", LEVEL_ACK, 1);
        check("t3_level", LEVEL, 3);
        tick();
        LEVEL_REQ_VALID = 1'b0;
        check("t3_ack_once", LEVEL_ACK, 0);
        run_until(800, "t3c");
        check("t3_step_p7", STEP, 1);

        // Level 7 gives a 3-pulse period
        tick();
        LEVEL_REQ = 3'd7; LEVEL_REQ_VALID = 1'b1;
        run_until(940, "t4a");
        check("t4_step", STEP, 1);
        tick();
        check("t4_ack", LEVEL_ACK, 1);
        check("t4_level", LEVEL, 7);
        tick();
        LEVEL_REQ_VALID = 1'b0;
        run_until(1000, "t4b");
        check("t4_step_p3a", STEP, 1);
        tick();
        run_until(1060, "t4c");
        check("t4_step_p3b", STEP, 1);
        tick();
        run_until(1070, "t4d");
        PAUSE_TOGGLE = 1'b1;
        tick();
        PAUSE_TOGGLE = 1'b0;
        check("t4_paused", {RUNNING, PAUSED}, 2'b01);
        LEVEL_REQ = 3'd5; LEVEL_REQ_VALID = 1'b1;
        tick();
        check("t4_pause_ack", LEVEL_ACK, 1);
        check("t4_pause_level", LEVEL, 5);
        tick();
        LEVEL_REQ_VALID = 1'b0;
        check("t4_no_double_ack", LEVEL_ACK, 0);
        run_until(1110, "t4e");
        PAUSE_TOGGLE = 1'b1;
        tick();
        PAUSE_TOGGLE = 1'b0;
        check("t4_resumed", RUNNING, 1);
        run_until(1200, "t4f");
        check("t4_step_p5", STEP, 1);

        // Pause on a due STEP: suppressed, then fires on first CE_1K after resume
        tick();
        run_until(1300, "t5a");
        PAUSE_TOGGLE = 1'b1;
        #1;
        check("t5_due_ce1k", CE_1K, 1);
        check("t5_step_supp", STEP, 0);
        tick();
        PAUSE_TOGGLE = 1'b0;
        check("t5_paused", PAUSED, 1);
        run_until(1330, "t5b");
        PAUSE_TOGGLE = 1'b1;
        tick();
        PAUSE_TOGGLE = 1'b0;
        check("t5_running", RUNNING, 1);
        run_until(1340, "t5c");
        check("t5_step_resume", STEP, 1);

        // GAME_OVER beats PAUSE_TOGGLE; restart keeps level with a full interval
        tick();
        run_until(1440, "t6a");
        GAME_OVER = 1'b1; PAUSE_TOGGLE = 1'b1;
        #1;
        check("t6_step_supp", STEP, 0);
        tick();
        GAME_OVER = 1'b0; PAUSE_TOGGLE = 1'b0;
        check("t6_over", {RUNNING, PAUSED, OVER}, 3'b001);
        run_until(1500, "t6b");
        START = 1'b1;
        tick();
        START = 1'b0;
        check("t6_restart", {RUNNING, OVER}, 2'b10);
        check("t6_level_kept", LEVEL, 5);
        run_until(1600, "t6c");
        check("t6_step_full", STEP, 1);
        tick();
        run_until(1610, "t6d");
        #2;
        RESET = 1'b1;
        #1;
        check("t6_async_status", {RUNNING, PAUSED, OVER, STEP, LEVEL_ACK}, 0);
        check("t6_async_level", LEVEL, 0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        cyc = 1;
        for (int i = 0; i < 8; i++) begin
            check("t6_post_ce20k", CE_20K, (cyc % 4) == 0);
            check("t6_post_idle", RUNNING, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
